// File: rtl/pldata_ram_arb_if.sv
// Beat, RAM-write, buffer-handshake and status bundle of the pldata RAM arbiter.
// master = beat sources / PS side, slave = arbiter.
interface pldata_ram_arb_if;
    logic        adc_valid_in;
    logic [31:0] adc_data_in;
    logic        adc_last_in;
    logic        gen_valid_in;
    logic [31:0] gen_data_in;
    logic        gen_last_in;
    logic        adc_ready_o;
    logic        gen_ready_o;
    logic        ram_wr_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic        bank_done_o;
    logic        bank_idx_o;
    logic [1:0]  buf_ack_in;
    logic        overflow_o;
    logic        busy_o;

    modport master (
        output adc_valid_in, adc_data_in, adc_last_in,
        output gen_valid_in, gen_data_in, gen_last_in,
        output buf_ack_in,
        input  adc_ready_o, gen_ready_o, ram_wr_o, ram_addr_o, ram_data_o,
        input  bank_done_o, bank_idx_o, overflow_o, busy_o
    );

    modport slave (
        input  adc_valid_in, adc_data_in, adc_last_in,
        input  gen_valid_in, gen_data_in, gen_last_in,
        input  buf_ack_in,
        output adc_ready_o, gen_ready_o, ram_wr_o, ram_addr_o, ram_data_o,
        output bank_done_o, bank_idx_o, overflow_o, busy_o
    );
endinterface

// File: rtl/pldata_ram_arb.sv
// Ping-pong pldata RAM writer arbitrating ADC vs generator beats; write lands 1 cycle after accept.
// ADC beats seen while not ready are dropped (sticky overflow); generator port needs PLDATA_ARB_TESTGEN_EN.
module pldata_ram_arb #(
    parameter int BANK_WORDS = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    pldata_ram_arb_if.slave bus
);
    localparam int WW = $clog2(BANK_WORDS);
`ifdef PLDATA_ARB_TESTGEN_EN
    localparam bit GEN_EN = 1'b1;
`else
    localparam bit GEN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN_ADC, OWN_GEN, WAIT_BUF} state_t;

    state_t          state_q, state_d, ret_q, ret_d, after_fill;
    logic            bank_q, bank_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [1:0]      full_q, full_d;
    logic            wr_q, wr_d, done_q, done_d, idx_q, idx_d, ovf_q, ovf_d;
    logic [9:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;

    logic            adc_rdy, gen_rdy, adc_acc, gen_acc, acc, beat_last, bank_end;
    logic [31:0]     beat_dat;

    // Readies are forced low while reset is asserted so every output reads 0.
    assign adc_rdy   = rst_n && (state_q == IDLE || state_q == OWN_ADC);
    assign gen_rdy   = rst_n && GEN_EN &&
                       ((state_q == IDLE && !bus.adc_valid_in) || state_q == OWN_GEN);
    assign adc_acc   = bus.adc_valid_in && adc_rdy;
    assign gen_acc   = bus.gen_valid_in && gen_rdy;
    assign acc       = adc_acc || gen_acc;
    assign beat_last = adc_acc ? bus.adc_last_in : bus.gen_last_in;
    assign beat_dat  = adc_acc ? bus.adc_data_in : bus.gen_data_in;
    assign bank_end  = acc && (beat_last || cnt_q == WW'(BANK_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        bank_d     = bank_q;
        cnt_d      = cnt_q;
        after_fill = IDLE;
        // Ack is applied before the completion set so a coinciding set wins.
        full_d     = full_q & ~bus.buf_ack_in;
        wr_d       = acc;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        ovf_d      = ovf_q | (bus.adc_valid_in & ~adc_rdy);
        if (acc) begin
            addr_d  = 10'({bank_q, cnt_q, 2'b00});
            data_d  = beat_dat;
            cnt_d   = cnt_q + WW'(1);
            state_d = adc_acc ? OWN_ADC : OWN_GEN;
            if (bank_end) begin
                done_d         = 1'b1;
                idx_d          = bank_q;
                full_d[bank_q] = 1'b1;
                bank_d         = ~bank_q;
                cnt_d          = '0;
                after_fill     = beat_last ? IDLE : (adc_acc ? OWN_ADC : OWN_GEN);
                state_d        = after_fill;
                if (full_q[~bank_q]) begin
                    state_d = WAIT_BUF;
                    ret_d   = after_fill;
                end
            end
        end else if (state_q == WAIT_BUF && !full_q[bank_q]) begin
            state_d = ret_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            bank_q  <= 1'b0;
            cnt_q   <= '0;
            full_q  <= 2'b00;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            idx_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.adc_ready_o = adc_rdy;
    assign bus.gen_ready_o = gen_rdy;
    assign bus.ram_wr_o    = wr_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_data_o  = data_q;
    assign bus.bank_done_o = done_q;
    assign bus.bank_idx_o  = idx_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_pldata_ram_arb.sv
// Bench for pldata_ram_arb: vector table, directed corner sequences and a randomized run vs a line/bank model.
module tb_pldata_ram_arb;
    localparam int BW = 128;
`ifdef PLDATA_ARB_TESTGEN_EN
    localparam bit GEN_EN_TB = 1'b1;
`else
    localparam bit GEN_EN_TB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pldata_ram_arb_if b();
    pldata_ram_arb #(.BANK_WORDS(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    int n_tot = 0;
    int n_bad = 0;

    // Model: owner 0=none 1=adc 2=gen; wait = blocked on the next bank being read out.
    int         m_owner, m_cnt;
    bit         m_wait, m_bank, m_ovf;
    bit [1:0]   m_full;
    bit         g_taken;
    int         n_done_dut, n_wr_dut;
    logic [9:0] last_addr;
    logic [31:0] last_dat;
    logic       last_idx;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic drive(input logic av, input logic [31:0] ad, input logic al,
                         input logic gv, input logic [31:0] gd, input logic gl,
                         input logic [1:0] ack);
        b.adc_valid_in = av; b.adc_data_in = ad; b.adc_last_in = al;
        b.gen_valid_in = gv; b.gen_data_in = gd; b.gen_last_in = gl;
        b.buf_ack_in   = ack;
    endtask

    task automatic observe();
        if (b.ram_wr_o === 1'b1) begin
            n_wr_dut++;
            last_addr = b.ram_addr_o;
            last_dat  = b.ram_data_o;
        end
        if (b.bank_done_o === 1'b1) begin
            n_done_dut++;
            last_idx = b.bank_idx_o;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("rst_wr", b.ram_wr_o, 0);       chk("rst_addr", b.ram_addr_o, 0);
        chk("rst_data", b.ram_data_o, 0);   chk("rst_done", b.bank_done_o, 0);
        chk("rst_idx", b.bank_idx_o, 0);    chk("rst_ovf", b.overflow_o, 0);
        chk("rst_busy", b.busy_o, 0);       chk("rst_adc_rdy", b.adc_ready_o, 0);
        chk("rst_gen_rdy", b.gen_ready_o, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_done", b.bank_done_o, 0);
        rst_n = 1'b1;
        m_owner = 0; m_cnt = 0; m_wait = 0; m_bank = 0; m_ovf = 0; m_full = 2'b00;
        n_done_dut = 0; n_wr_dut = 0; g_taken = 0;
    endtask

    // One clock of stimulus, checked against the model.
    task automatic step(input logic av, input logic [31:0] ad, input logic al,
                        input logic gv, input logic [31:0] gd, input logic gl,
                        input logic [1:0] ack);
        bit ra, rg, acc_a, acc_g, last, done;
        bit [1:0] fpre;
        logic [9:0] e_addr;
        logic [31:0] e_dat;
        bit e_idx;
        drive(av, ad, al, gv, gd, gl, ack);
        #1;
        ra = !m_wait && (m_owner != 2);
        rg = GEN_EN_TB && !m_wait && (m_owner == 2 || (m_owner == 0 && !av));
        chk("adc_ready", b.adc_ready_o, ra);
        chk("gen_ready", b.gen_ready_o, rg);
        acc_a = av && ra;
        acc_g = gv && rg && !acc_a;
        g_taken = acc_g;
        fpre = m_full;
        m_full = fpre & ~ack;
        done = 0; e_addr = 0; e_dat = 0; e_idx = 0;
        if (av && !ra) m_ovf = 1;
        if (m_wait) begin
            if (!fpre[m_bank]) m_wait = 0;
        end else if (acc_a || acc_g) begin
            last   = acc_a ? al : gl;
            e_dat  = acc_a ? ad : gd;
            e_addr = 10'(m_bank * BW * 4 + m_cnt * 4);
            done   = last || (m_cnt == BW - 1);
            e_idx  = m_bank;
            m_owner = last ? 0 : (acc_a ? 1 : 2);
            m_cnt++;
            if (done) begin
                m_full[m_bank] = 1;
                m_bank = ~m_bank;
                m_cnt = 0;
                m_wait = fpre[m_bank];
            end
        end
        @(posedge clk);
        #1;
        observe();
        chk("ram_wr", b.ram_wr_o, acc_a || acc_g);
        if (acc_a || acc_g) begin
            chk("ram_addr", b.ram_addr_o, e_addr);
            chk("ram_data", b.ram_data_o, e_dat);
        end
        chk("bank_done", b.bank_done_o, done);
        if (done) chk("bank_idx", b.bank_idx_o, e_idx);
        chk("overflow", b.overflow_o, m_ovf);
        chk("busy", b.busy_o, (m_owner != 0) || m_wait);
    endtask

    typedef struct {
        logic av; logic [31:0] ad; logic al; logic [1:0] ack;
        logic e_rdy; logic e_wr; logic [9:0] e_addr; logic [31:0] e_dat;
        logic e_done; logic e_idx; logic e_ovf; logic e_busy;
    } vec_t;

    function automatic vec_t mk(logic av, logic [31:0] ad, logic al, logic [1:0] ack,
                                logic e_rdy, logic e_wr, logic [9:0] e_addr,
                                logic e_done, logic e_idx, logic e_ovf, logic e_busy);
        vec_t v;
        v.av = av; v.ad = ad; v.al = al; v.ack = ack;
        v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_addr = e_addr; v.e_dat = ad;
        v.e_done = e_done; v.e_idx = e_idx; v.e_ovf = e_ovf; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t tv[15];

    initial begin
        logic gv, gl, av, al;
        logic [31:0] gd, ad;
        logic [1:0] ack;

        // Short lines exercising bank alternation, WAIT_BUF, ack release and set-over-ack.
        tv[0]  = mk(0, 32'h00, 0, 2'b00, 1, 0, 10'h000, 0, 0, 0, 0);
        tv[1]  = mk(1, 32'h11, 0, 2'b00, 1, 1, 10'h000, 0, 0, 0, 1);
        tv[2]  = mk(1, 32'h22, 1, 2'b00, 1, 1, 10'h004, 1, 0, 0, 0);
        tv[3]  = mk(1, 32'h33, 1, 2'b00, 1, 1, 10'h200, 1, 1, 0, 1);
        tv[4]  = mk(1, 32'h44, 0, 2'b00, 0, 0, 10'h000, 0, 0, 1, 1);
        tv[5]  = mk(0, 32'h00, 0, 2'b01, 0, 0, 10'h000, 0, 0, 1, 1);
        tv[6]  = mk(0, 32'h00, 0, 2'b00, 0, 0, 10'h000, 0, 0, 1, 0);
        tv[7]  = mk(1, 32'h55, 0, 2'b00, 1, 1, 10'h000, 0, 0, 1, 1);
        tv[8]  = mk(1, 32'h66, 1, 2'b01, 1, 1, 10'h004, 1, 0, 1, 1);
        tv[9]  = mk(0, 32'h00, 0, 2'b10, 0, 0, 10'h000, 0, 0, 1, 1);
        tv[10] = mk(0, 32'h00, 0, 2'b00, 0, 0, 10'h000, 0, 0, 1, 0);
        tv[11] = mk(1, 32'h77, 1, 2'b00, 1, 1, 10'h200, 1, 1, 1, 1);
        tv[12] = mk(0, 32'h00, 0, 2'b00, 0, 0, 10'h000, 0, 0, 1, 1);
        tv[13] = mk(0, 32'h00, 0, 2'b01, 0, 0, 10'h000, 0, 0, 1, 1);
        tv[14] = mk(0, 32'h00, 0, 2'b00, 0, 0, 10'h000, 0, 0, 1, 0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].av, tv[i].ad, tv[i].al, 0, 0, 0, tv[i].ack);
            #1;
            chk($sformatf("v%0d_rdy", i), b.adc_ready_o, tv[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr", i), b.ram_wr_o, tv[i].e_wr);
            if (tv[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), b.ram_addr_o, tv[i].e_addr);
                chk($sformatf("v%0d_data", i), b.ram_data_o, tv[i].e_dat);
            end
            chk($sformatf("v%0d_done", i), b.bank_done_o, tv[i].e_done);
            if (tv[i].e_done) chk($sformatf("v%0d_idx", i), b.bank_idx_o, tv[i].e_idx);
            chk($sformatf("v%0d_ovf", i), b.overflow_o, tv[i].e_ovf);
            chk($sformatf("v%0d_busy", i), b.busy_o, tv[i].e_busy);
        end

        // Full 128-beat ADC line ending exactly at the bank boundary.
        do_reset();
        for (int i = 0; i < 128; i++) step(1, i, i == 127, 0, 0, 0, 2'b00);
        chk("line128_dones", n_done_dut, 1);
        chk("line128_last_addr", last_addr, 10'h1FC);
        chk("line128_idx", last_idx, 0);
        chk("line128_busy", b.busy_o, 0);

        // Both banks filled without ack, ADC beat dropped, ack frees bank 0.
        do_reset();
        for (int i = 0; i < 256; i++) step(1, 32'h1000 + i, 0, 0, 0, 0, 2'b00);
        chk("fill2_dones", n_done_dut, 2);
        step(1, 32'hDEAD, 0, 0, 0, 0, 2'b00);
        chk("fill2_ovf", b.overflow_o, 1);
        step(0, 0, 0, 0, 0, 0, 2'b01);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        step(1, 32'hBEEF, 0, 0, 0, 0, 2'b00);
        chk("fill2_resume_addr", last_addr, 10'h000);
        chk("fill2_resume_data", last_dat, 32'hBEEF);
        repeat (3) step(0, 0, 0, 0, 0, 0, 2'b00);
        chk("fill2_ovf_sticky", b.overflow_o, 1);

        // Reset in the middle of a line.
        do_reset();
        for (int i = 0; i < 50; i++) step(1, 32'h500 + i, 0, 0, 0, 0, 2'b00);
        do_reset();
        chk("midrst_dones", n_done_dut, 0);
        step(1, 32'hCAFE, 0, 0, 0, 0, 2'b00);
        chk("midrst_addr", last_addr, 10'h000);

`ifdef PLDATA_ARB_TESTGEN_EN
        do_reset();
        step(1, 32'hA0, 0, 1, 32'hB0, 0, 2'b00);
        for (int k = 1; k < 4; k++) step(1, 32'hA0 + k, k == 3, 1, 32'hB0, 0, 2'b00);
        step(0, 0, 0, 1, 32'hB0, 0, 2'b00);
        chk("tie_gen_addr", last_addr, 10'h200);
        chk("tie_gen_data", last_dat, 32'hB0);

        do_reset();
        for (int i = 0; i < 200; i++) step(0, 0, 0, 1, i, i == 199, 2'b00);
        chk("gen200_dones", n_done_dut, 2);
        chk("gen200_last_addr", last_addr, 10'h31C);
        chk("gen200_idx", last_idx, 1);
`else
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 32'h900 + i, 1, 2'b00);
        chk("nogen_writes", n_wr_dut, 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        gv = 0; gd = 0; gl = 0;
        for (int i = 0; i < 4000; i++) begin
            av  = ($urandom_range(0, 9) < 7);
            ad  = $urandom;
            al  = ($urandom_range(0, 39) == 0);
            if (!gv || g_taken) begin
                gv = ($urandom_range(0, 3) == 0);
                gd = $urandom;
                gl = ($urandom_range(0, 29) == 0);
            end
            ack = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            step(av, ad, al, gv, gd, gl, ack);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end
endmodule
